// File: rtl/packet_tx_framer_if.sv
// Sample-stream bundle for packet_tx_framer: upstream payload and downstream tx.
// master = framer side, slave = environment side (source and sink).
interface packet_tx_framer_if #(
    parameter int SAMPLE_W = 12
);
    logic signed [SAMPLE_W-1:0] payload_r_i;
    logic signed [SAMPLE_W-1:0] payload_i_i;
    logic                       payload_valid_i;
    logic                       payload_ready_o;
    logic signed [SAMPLE_W-1:0] tx_r_o;
    logic signed [SAMPLE_W-1:0] tx_i_o;
    logic                       tx_valid_o;
    logic                       tx_ready_i;
    logic                       tx_sof_o;
    logic                       tx_last_o;

    modport master (
        input  payload_r_i, payload_i_i, payload_valid_i, tx_ready_i,
        output payload_ready_o, tx_r_o, tx_i_o, tx_valid_o,
        output tx_sof_o, tx_last_o
    );

    modport slave (
        output payload_r_i, payload_i_i, payload_valid_i, tx_ready_i,
        input  payload_ready_o, tx_r_o, tx_i_o, tx_valid_o,
        input  tx_sof_o, tx_last_o
    );
endinterface

// File: rtl/packet_tx_framer.sv
// Transmit framer: repeated PN preamble, pass-through payload, zero guard.
// Ports: clk, rst, start_i, payload_len_i, bus (stream if), busy_o, done_o.
module packet_tx_framer #(
    parameter int                 SAMPLE_W  = 12,
    parameter int                 SYM_LEN   = 16,
    parameter int                 NUM_REPS  = 2,
    parameter int                 GUARD_LEN = 4,
    parameter int                 AMP       = 1024,
    parameter logic [SYM_LEN-1:0] PN_SEQ    = 16'hA5C3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [15:0]         payload_len_i,
    packet_tx_framer_if.master  bus,
    output logic                busy_o,
    output logic                done_o
);
    localparam int KW = $clog2(SYM_LEN);
    localparam int RW = $clog2(NUM_REPS);
    localparam int GW = $clog2(GUARD_LEN + 1);

    localparam logic [KW-1:0] K_MAX = KW'(SYM_LEN - 1);
    localparam logic [RW-1:0] R_MAX = RW'(NUM_REPS - 1);
    localparam logic [GW-1:0] G_END = GW'(GUARD_LEN);
    localparam logic [GW-1:0] G_LST = GW'(GUARD_LEN - 1);

    localparam logic signed [SAMPLE_W-1:0] AMP_P = SAMPLE_W'(AMP);
    localparam logic signed [SAMPLE_W-1:0] AMP_N = SAMPLE_W'(-AMP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_GUARD,
        S_DONE
    } state_t;

    // The state names the source of the NEXT output-register load, so a
    // new source can be loaded on the same edge the previous sample
    // leaves; this keeps the stream bubble-free across phase boundaries.
    state_t                     state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    logic [RW-1:0]              rep_q, rep_d;
    logic [15:0]                rem_q, rem_d;
    logic [GW-1:0]              g_q, g_d;
    logic signed [SAMPLE_W-1:0] r_q, r_d;
    logic signed [SAMPLE_W-1:0] i_q, i_d;
    logic                       v_q, v_d;
    logic                       sof_q, sof_d;
    logic                       last_q, last_d;
    logic                       adv;
    logic                       pready;
    logic signed [SAMPLE_W-1:0] pn_smp;

    // Output register may take a new value when empty or being drained.
    assign adv    = !v_q || bus.tx_ready_i;
    assign pn_smp = PN_SEQ[k_q] ? AMP_N : AMP_P;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rep_d   = rep_q;
        rem_d   = rem_q;
        g_d     = g_q;
        r_d     = r_q;
        i_d     = i_q;
        v_d     = v_q;
        sof_d   = sof_q;
        last_d  = last_q;
        pready  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_PREAMBLE;
                    rem_d   = payload_len_i;
                    r_d     = pn_smp;
                    i_d     = pn_smp;
                    v_d     = 1'b1;
                    sof_d   = 1'b1;
                    last_d  = 1'b0;
                    k_d     = k_q + KW'(1);
                    rep_d   = '0;
                end
            end
            S_PREAMBLE: begin
                if (adv) begin
                    r_d   = pn_smp;
                    i_d   = pn_smp;
                    v_d   = 1'b1;
                    sof_d = 1'b0;
                    if (k_q == K_MAX) begin
                        k_d = '0;
                        if (rep_q == R_MAX) begin
                            rep_d   = '0;
                            g_d     = '0;
                            state_d = (rem_q == 16'd0) ? S_GUARD
                                                       : S_PAYLOAD;
                        end else begin
                            rep_d = rep_q + RW'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_PAYLOAD: begin
                pready = adv;
                if (adv) begin
                    if (bus.payload_valid_i) begin
                        r_d   = bus.payload_r_i;
                        i_d   = bus.payload_i_i;
                        v_d   = 1'b1;
                        sof_d = 1'b0;
                        rem_d = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            g_d     = '0;
                            state_d = S_GUARD;
                        end
                    end else begin
                        v_d = 1'b0;
                    end
                end
            end
            S_GUARD: begin
                if (adv) begin
                    if (g_q != G_END) begin
                        r_d    = '0;
                        i_d    = '0;
                        v_d    = 1'b1;
                        sof_d  = 1'b0;
                        last_d = (g_q == G_LST);
                        g_d    = g_q + GW'(1);
                    end else begin
                        // all guard samples loaded: this is the last beat
                        v_d     = 1'b0;
                        last_d  = 1'b0;
                        g_d     = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            rep_q   <= '0;
            rem_q   <= '0;
            g_q     <= '0;
            r_q     <= '0;
            i_q     <= '0;
            v_q     <= 1'b0;
            sof_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rep_q   <= rep_d;
            rem_q   <= rem_d;
            g_q     <= g_d;
            r_q     <= r_d;
            i_q     <= i_d;
            v_q     <= v_d;
            sof_q   <= sof_d;
            last_q  <= last_d;
        end
    end

    assign bus.tx_r_o          = r_q;
    assign bus.tx_i_o          = i_q;
    assign bus.tx_valid_o      = v_q;
    assign bus.tx_sof_o        = sof_q;
    assign bus.tx_last_o       = last_q;
    assign bus.payload_ready_o = pready;
    assign busy_o              = (state_q != S_IDLE);
    assign done_o              = (state_q == S_DONE);
endmodule

// File: doc/packet_tx_framer.md
# packet_tx_framer

Transmit-side framer that pairs with the packet detector datapath. On a start request it emits a complex sample stream: a preamble of `NUM_REPS` identical training symbols of `SYM_LEN` samples each, then `payload_len_i` payload samples passed through from an upstream source, then `GUARD_LEN` zero samples. The repeated-symbol preamble is what the receiver's autocorrelation metric locks onto, and the payload count matches the receiver's payload length counter. The block sits between the payload sample source and the DAC/channel model.

## Interface
- `SAMPLE_W`, 12: width of each signed real/imag sample.
- `SYM_LEN`, 16: samples per training symbol; must be at least 2.
- `NUM_REPS`, 2: number of identical training symbols; must be at least 2.
- `GUARD_LEN`, 4: zero samples appended after the payload; must be at least 1.
- `AMP`, 1024: preamble amplitude; positive and representable in `SAMPLE_W` signed.
- `PN_SEQ`, 16'hA5C3: `SYM_LEN`-bit sign pattern for the training symbol.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: frame request; sampled only in IDLE.
- `payload_len_i` in 16: payload sample count; latched on an accepted start.
- `payload_r_i` / `payload_i_i` in SAMPLE_W each: upstream payload sample.
- `payload_valid_i` in 1: upstream sample valid.
- `payload_ready_o` out 1: the framer is accepting an upstream sample this cycle.
- `tx_r_o` / `tx_i_o` out SAMPLE_W each: output sample, registered.
- `tx_valid_o` out 1: output sample valid, registered.
- `tx_ready_i` in 1: downstream accepts the sample.
- `tx_sof_o` out 1: qualifies the first preamble sample.
- `tx_last_o` out 1: qualifies the final guard sample.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse after the last sample is accepted.

## Operation
- **States:** IDLE, PREAMBLE, PAYLOAD, GUARD, DONE.
- **IDLE → PREAMBLE:** on `start_i`=1. This latches `payload_len_i` and loads the first preamble sample into the output register. `start_i` is ignored in every other state.
- **Preamble sample k** (k = 0..SYM_LEN-1, repeated `NUM_REPS` times):
  - `tx_r_o` = `tx_i_o` = -`AMP` if `PN_SEQ[k]` = 1, otherwise +`AMP`.
  - Counters: sample index `k` and repetition index `rep`.
- **PREAMBLE → PAYLOAD:** after the last preamble sample is accepted. If the latched length is 0, go directly to GUARD.
- **PAYLOAD:**
  - `payload_ready_o` = `!tx_valid_o || tx_ready_i`; it is 0 in all other states.
  - A payload beat (`payload_valid_i` & `payload_ready_o`) loads the output register and decrements the remaining count.
  - If upstream is not valid, `tx_valid_o` drops, creating a bubble. This is legal.
  - When the last payload beat is loaded, go to GUARD.
- **GUARD:** emits `GUARD_LEN` samples of 0+0j. `tx_last_o` is high with the final one.
- **DONE:** entered when the `tx_last_o` sample is accepted. `done_o` is 1 for exactly this one cycle, then the FSM returns to IDLE.
- **Output handshake:** standard valid/ready. While `tx_valid_o` & !`tx_ready_i`, the outputs `tx_r_o`, `tx_i_o`, `tx_sof_o` and `tx_last_o` hold stable. No sample is dropped or duplicated.
- **Arithmetic:** payload is passed through bit-exact with no scaling. The payload counter is 16-bit and never wraps; the length is decremented only on beats.

## Timing
- **Reset values:** all outputs 0 (`tx_r_o`, `tx_i_o`, `tx_valid_o`, `tx_sof_o`, `tx_last_o`, `payload_ready_o`, `busy_o`, `done_o`). State is IDLE and all counters are 0.
- **Start latency:** with `start_i` sampled high at edge N, in the cycle after edge N `busy_o` = 1, `tx_valid_o` = 1 and `tx_sof_o` = 1.
- **Frame length:** exactly `NUM_REPS`·`SYM_LEN` + L + `GUARD_LEN` accepted samples, where L is the latched length.
- **Full rate:** with `tx_ready_i`=1 and `payload_valid_i`=1 throughout, one sample is output per cycle with no bubbles at state boundaries.
- **`done_o`:** high in the cycle after the `tx_last_o` beat is accepted. `busy_o` is 0 in the following cycle, and a new start can be accepted then.
- **`payload_len_i`:** changes after the latch have no effect on the current frame.
- **Reset mid-frame:** immediately returns to IDLE with all outputs at 0. The partial frame is abandoned and no `done_o` pulse is issued.

## Test plan
- **Basic frame:** `SYM_LEN`=16, `NUM_REPS`=2, `GUARD_LEN`=4, `AMP`=1024, `PN_SEQ`=16'hA5C3, L=8, ready and valid held at 1.
  - 44 contiguous beats.
  - Sample 0 is -1024 (bit 0 = 1); sample 2 is +1024.
  - Samples 16..31 equal samples 0..15.
  - Payload is bit-exact; the last 4 samples are 0; `tx_last_o` is on beat 44.
  - `done_o` is high for exactly 1 cycle.
- **Zero length:** L=0 → 36 beats; GUARD directly follows the preamble; `payload_ready_o` never goes high.
- **Backpressure:** `tx_ready_i` toggles pseudo-randomly (50%) → same 44-sample sequence; outputs stay stable on every stalled cycle.
- **Upstream gaps:** `payload_valid_i` low for 3 cycles mid-payload → `tx_valid_o` drops for those cycles; payload order is preserved; the frame still contains 8 payload samples.
- **Start handling:** `start_i` held high through the frame → a second frame starts in the cycle after `busy_o` falls. A start pulse while busy has no effect.
- **Reset mid-frame:** `rst` pulse at beat 20 → all outputs are 0 within the same cycle; no `done_o` pulse; a subsequent start produces a full correct frame.
